proc_datapath: RTL and testbench

- Execution side of the 10-bit processor. It consumes the per-step control word from the instruction controller and returns the current instruction (INSTR) and timestep (T) to it.
- Contains the instruction register, a 4x10 register file, the A operand register, the ALU, the G result register, the shared 10-bit bus and the 2-bit timestep counter.
- Sits between the external data input (DIN) and the controller.

---
 rtl/proc_datapath.sv | 149 ++++++++++++++
 tb/tb_proc_datapath.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_datapath.sv
// Execution datapath of the 10-bit processor: IR, register file, A/G registers,
// ALU, shared bus and the 2-bit timestep counter driven by the controller.
module proc_datapath #(
    parameter int WIDTH = 10,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Ext,
    input  logic             IRin,
    input  logic             ENW,
    input  logic             ENR,
    input  logic [1:0]       Rin,
    input  logic [1:0]       Rout,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    input  logic [3:0]       ALUcont,
    input  logic             Clr,
    output logic [9:0]       INSTR,
    output logic [1:0]       T,
    output logic [WIDTH-1:0] BUS,
    output logic             bus_conflict,
    output logic             done
);

    logic [WIDTH-1:0]        reg_q [NREGS];
    logic [NREGS-1:0]        wr_en;
    logic [WIDTH-1:0]        a_q, a_d;
    logic [WIDTH-1:0]        g_q, g_d;
    logic [9:0]              ir_q, ir_d;
    logic [1:0]              t_q, t_d;
    logic                    conflict_q, conflict_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        bus_w;
    logic [WIDTH-1:0]        alu_y;
    logic signed [WIDTH-1:0] asr_y;
    logic [3:0]              shamt;
    logic                    sh_ovf;
    logic                    multi_drv;

    // Fixed-priority bus source select; lower-priority drivers are simply masked.
    always_comb begin
        if (Ext) begin
            bus_w = DIN;
        end else if (Gout) begin
            bus_w = g_q;
        end else if (ENR) begin
            bus_w = reg_q[Rout];
        end else begin
            bus_w = '0;
        end
    end

    assign multi_drv = (Ext & Gout) | (Ext & ENR) | (Gout & ENR);

    assign shamt  = bus_w[3:0];
    assign sh_ovf = ({28'd0, shamt} >= 32'(WIDTH));
    assign asr_y  = $signed(a_q) >>> shamt;

    always_comb begin
        alu_y = bus_w;
        case (ALUcont)
            4'b0010: alu_y = a_q + bus_w;
            4'b0011: alu_y = a_q - bus_w;
            4'b0100: alu_y = '0 - bus_w;
            4'b0101: alu_y = ~bus_w;
            4'b0110: alu_y = a_q & bus_w;
            4'b0111: alu_y = a_q | bus_w;
            4'b1000: alu_y = a_q ^ bus_w;
            4'b1001: alu_y = sh_ovf ? '0 : (a_q << shamt);
            4'b1010: alu_y = sh_ovf ? '0 : (a_q >> shamt);
            4'b1011: begin
                if (sh_ovf) begin
                    alu_y = {WIDTH{a_q[WIDTH-1]}};
                end else begin
                    alu_y = asr_y;
                end
            end
            default: alu_y = bus_w;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr_en
            assign wr_en[gi] = en & ENW & (Rin == 2'(gi));
        end
    endgenerate

    // Writes capture the pre-edge bus, so a same-cycle read of the target sees the old value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                reg_q[i] <= '0;
            end else if (wr_en[i]) begin
                reg_q[i] <= bus_w;
            end
        end
    end

    always_comb begin
        ir_d       = ir_q;
        a_d        = a_q;
        g_d        = g_q;
        t_d        = t_q;
        conflict_d = conflict_q;
        done_d     = 1'b0;
        if (en) begin
            if (IRin) ir_d = bus_w[9:0];
            if (Ain)  a_d  = bus_w;
            if (Gin)  g_d  = alu_y;
            if (multi_drv) conflict_d = 1'b1;
            if (Clr) begin
                t_d    = 2'd0;
                done_d = 1'b1;
            end else begin
                t_d = t_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            a_q        <= '0;
            g_q        <= '0;
            t_q        <= '0;
            conflict_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            a_q        <= a_d;
            g_q        <= g_d;
            t_q        <= t_d;
            conflict_q <= conflict_d;
            done_q     <= done_d;
        end
    end

    assign INSTR        = ir_q;
    assign T            = t_q;
    assign BUS          = bus_w;
    assign bus_conflict = conflict_q;
    assign done         = done_q;

endmodule

// File: tb/tb_proc_datapath.sv
// Self-checking bench for proc_datapath: directed scenarios plus randomized steps
// compared against an arithmetic reference model of the datapath.
module tb_proc_datapath;

    localparam int MASK = 1023;

    logic       clk;
    logic       rst, en, Ext, IRin, ENW, ENR, Ain, Gin, Gout, Clr;
    logic [9:0] DIN;
    logic [1:0] Rin, Rout;
    logic [3:0] ALUcont;
    logic [9:0] INSTR;
    logic [1:0] T;
    logic [9:0] BUS;
    logic       bus_conflict, done;

    int n_chk = 0;
    int n_err = 0;
    int n_step = 0;
    logic [9:0] last_bus;
    logic [9:0] v;

    // Reference model state
    int m_reg [4];
    int m_a, m_g, m_ir, m_t, m_done, m_conf;

    proc_datapath #(.WIDTH(10), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .en(en), .DIN(DIN), .Ext(Ext), .IRin(IRin),
        .ENW(ENW), .ENR(ENR), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .ALUcont(ALUcont), .Clr(Clr), .INSTR(INSTR), .T(T),
        .BUS(BUS), .bus_conflict(bus_conflict), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_bus();
        if (Ext) return int'(DIN);
        if (Gout) return m_g;
        if (ENR) return m_reg[Rout];
        return 0;
    endfunction

    function automatic int m_alu(input int op, input int a, input int b);
        int sh, sa, r;
        sh = b % 16;
        sa = (a >= 512) ? a - 1024 : a;
        case (op)
            2:  r = a + b;
            3:  r = a - b;
            4:  r = -b;
            5:  r = ~b;
            6:  r = a & b;
            7:  r = a | b;
            8:  r = a ^ b;
            9:  r = a << sh;
            10: r = a >> sh;
            11: r = sa >>> sh;
            default: r = b;
        endcase
        return r & MASK;
    endfunction

    task automatic m_update();
        int b, new_g;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_a = 0; m_g = 0; m_ir = 0; m_t = 0; m_done = 0; m_conf = 0;
        end else if (!en) begin
            m_done = 0;
        end else begin
            b = m_bus();
            new_g = m_alu(int'(ALUcont), m_a, b);
            if (int'(Ext) + int'(Gout) + int'(ENR) > 1) m_conf = 1;
            if (IRin) m_ir = b;
            if (ENW) m_reg[Rin] = b;
            if (Ain) m_a = b;
            if (Gin) m_g = new_g;
            if (Clr) begin
                m_t = 0;
                m_done = 1;
            end else begin
                m_t = (m_t + 1) % 4;
                m_done = 0;
            end
        end
    endtask

    // One clock step: bus checked before the edge, registered outputs just after it.
    task automatic step();
        int eb;
        eb = m_bus();
        #1;
        last_bus = BUS;
        chk("bus", {22'd0, BUS}, eb);
        @(posedge clk);
        m_update();
        #1;
        chk("T", {30'd0, T}, m_t);
        chk("INSTR", {22'd0, INSTR}, m_ir);
        chk("done", {31'd0, done}, m_done);
        chk("bus_conflict", {31'd0, bus_conflict}, m_conf);
        n_step++;
        $display("step %0d rst=%0b en=%0b bus=%h T=%0d INSTR=%h done=%0b conf=%0b",
                 n_step, rst, en, last_bus, T, INSTR, done, bus_conflict);
    endtask

    task automatic set_idle();
        rst = 0; en = 1; Ext = 0; IRin = 0; ENW = 0; ENR = 0; Ain = 0;
        Gin = 0; Gout = 0; Clr = 0; DIN = '0; Rin = '0; Rout = '0; ALUcont = '0;
    endtask

    task automatic peek_reg(input int r, output logic [9:0] val);
        set_idle(); en = 0; ENR = 1; Rout = r[1:0];
        step();
        val = last_bus;
    endtask

    task automatic peek_g(output logic [9:0] val);
        set_idle(); en = 0; Gout = 1;
        step();
        val = last_bus;
    endtask

    task automatic load_reg(input int r, input logic [9:0] val);
        set_idle(); Ext = 1; DIN = val; ENW = 1; Rin = r[1:0];
        step();
    endtask

    task automatic gin_op(input logic [3:0] op, input logic [9:0] b);
        set_idle(); Ext = 1; DIN = b; Gin = 1; ALUcont = op;
        step();
    endtask

    task automatic rand_ctl(input bit allow_rst);
        int drv;
        set_idle();
        rst  = allow_rst && ($urandom_range(0, 49) == 0);
        en   = ($urandom_range(0, 9) != 0);
        drv  = $urandom_range(0, 3);
        Ext  = (drv == 1); Gout = (drv == 2); ENR = (drv == 3);
        if ($urandom_range(0, 29) == 0) begin
            Ext = 1; Gout = $urandom_range(0, 1); ENR = !Gout;
        end
        DIN = 10'($urandom); Rin = 2'($urandom); Rout = 2'($urandom);
        IRin = 1'($urandom); ENW = 1'($urandom); Ain = 1'($urandom);
        Gin = 1'($urandom); ALUcont = 4'($urandom);
        Clr = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 0;
        m_a = 0; m_g = 0; m_ir = 0; m_t = 0; m_done = 0; m_conf = 0;
        set_idle();
        rst = 1;
        @(posedge clk);
        #1;
        step();

        // Reset after random activity
        for (int i = 0; i < 20; i++) begin
            rand_ctl(1'b0);
            step();
        end
        rand_ctl(1'b0); rst = 1;
        step();
        chk("rst_T", {30'd0, T}, 0);
        chk("rst_INSTR", {22'd0, INSTR}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_conflict", {31'd0, bus_conflict}, 0);
        for (int r = 0; r < 4; r++) begin
            peek_reg(r, v);
            chk("rst_reg", {22'd0, v}, 0);
        end
        peek_g(v);
        chk("rst_G", {22'd0, v}, 0);
        set_idle(); Ext = 1; DIN = 10'h000; Gin = 1; ALUcont = 4'b0010; Clr = 1;
        step();
        peek_g(v);
        chk("rst_A", {22'd0, v}, 0);

        // Load-immediate instruction into R1
        set_idle(); Ext = 1; DIN = 10'h040; IRin = 1;
        step();
        chk("load_T1", {30'd0, T}, 1);
        set_idle(); Ext = 1; DIN = 10'h155; ENW = 1; Rin = 2'd1; Clr = 1;
        step();
        chk("load_INSTR", {22'd0, INSTR}, 10'h040);
        chk("load_done", {31'd0, done}, 1);
        chk("load_T0", {30'd0, T}, 0);
        peek_reg(1, v);
        chk("load_R1", {22'd0, v}, 10'h155);
        chk("done_pulse", {31'd0, done}, 0);

        // Add with wrap-around
        load_reg(0, 10'h3FF);
        load_reg(1, 10'h002);
        set_idle(); ENR = 1; Rout = 2'd0; Ain = 1;
        step();
        set_idle(); ENR = 1; Rout = 2'd1; Gin = 1; ALUcont = 4'b0010;
        step();
        set_idle(); Gout = 1; ENW = 1; Rin = 2'd0; Clr = 1;
        step();
        peek_reg(0, v);
        chk("add_wrap_R0", {22'd0, v}, 10'h001);

        // Shifts
        set_idle(); Ext = 1; DIN = 10'h200; Ain = 1;
        step();
        gin_op(4'b1011, 10'd1);
        peek_g(v);
        chk("asr_1", {22'd0, v}, 10'h300);
        gin_op(4'b1010, 10'd10);
        peek_g(v);
        chk("lsr_10", {22'd0, v}, 10'h000);
        gin_op(4'b1011, 10'd15);
        peek_g(v);
        chk("asr_15", {22'd0, v}, 10'h3FF);
        set_idle(); Ext = 1; DIN = 10'h0C1; Ain = 1;
        step();
        gin_op(4'b1001, 10'd3);
        peek_g(v);
        chk("lsl_3", {22'd0, v}, 10'h208);

        // Copy a register onto itself
        load_reg(2, 10'h0AB);
        set_idle(); ENR = 1; Rout = 2'd2; ENW = 1; Rin = 2'd2;
        step();
        chk("copy_bus", {22'd0, last_bus}, 10'h0AB);
        peek_reg(2, v);
        chk("copy_R2", {22'd0, v}, 10'h0AB);
        chk("copy_noconf", {31'd0, bus_conflict}, 0);

        // Stall mid-instruction
        set_idle(); Clr = 1;
        step();
        set_idle(); Ext = 1; DIN = 10'h0C0; IRin = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_ctl(1'b0); en = 0;
            step();
            chk("stall_T", {30'd0, T}, 1);
        end
        set_idle(); Ext = 1; DIN = 10'h2A5; ENW = 1; Rin = 2'd3; Clr = 1;
        step();
        chk("resume_T", {30'd0, T}, 0);
        chk("resume_done", {31'd0, done}, 1);
        chk("resume_INSTR", {22'd0, INSTR}, 10'h0C0);
        peek_reg(3, v);
        chk("resume_R3", {22'd0, v}, 10'h2A5);
        peek_g(v);
        chk("stall_G", {22'd0, v}, 10'h208);

        // Bus conflict, sticky until reset
        set_idle(); Ext = 1; Gout = 1; DIN = 10'h123;
        step();
        chk("conf_bus", {22'd0, last_bus}, 10'h123);
        chk("conf_set", {31'd0, bus_conflict}, 1);
        for (int i = 0; i < 3; i++) begin
            rand_ctl(1'b0);
            step();
        end
        chk("conf_sticky", {31'd0, bus_conflict}, 1);
        set_idle(); rst = 1;
        step();
        chk("conf_cleared", {31'd0, bus_conflict}, 0);

        // Randomized steps against the model
        for (int i = 0; i < 300; i++) begin
            rand_ctl(1'b1);
            step();
            if (i % 50 == 49) begin
                for (int r = 0; r < 4; r++) begin
                    peek_reg(r, v);
                end
                peek_g(v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
